regfile_writeback_queue: RTL
============================

Name: regfile_writeback_queue

Overview:
- Write-side initiator for the 16-entry register file: collects writeback requests from the ALU and load (memory) paths and drives the register file write port (controle/entrada/wr) at most one write per cycle.
- Buffers requests in a small in-order FIFO so both producers can retire in the same cycle.
- Reports per-read-index pending status so the decode stage can stall on rs/rt read-after-write hazards.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width. Only indices 0..15 are implemented.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- mem_valid  in  1  load-path writeback request
- mem_ready  out  1  load-path accept
- mem_addr  in  ADDR_W  load destination index
- mem_data  in  DATA_W  load data
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU accept
- alu_addr  in  ADDR_W  ALU destination index
- alu_data  in  DATA_W  ALU result
- wb_controle  out  ADDR_W  to register file controle
- wb_entrada  out  DATA_W  to register file entrada
- wb_wr  out  1  to register file wr
- rs  in  ADDR_W  decode read index A
- rt  in  ADDR_W  decode read index B
- rs_pending  out  1  write to rs still in flight
- rt_pending  out  1  write to rt still in flight
- count  out  clog2(DEPTH)+1  current FIFO occupancy
- drop_err  out  1  one-cycle pulse: an out-of-range request was discarded

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied; count=0.
  - wb_wr=0, wb_controle=0, wb_entrada=0, drop_err=0.
  - mem_ready=0, alu_ready=0; rs_pending=0, rt_pending=0.
  - Reset mid-operation discards all queued writes with no partial write issued.
- Handshake: a transfer occurs on a rising edge when valid&ready.
  - valid must be held until the transfer; addr and data must stay stable while valid is high.
  - ready never depends on the same source's valid.
- Ready rules, with free = DEPTH - count (occupancy at the start of the cycle; a same-cycle dequeue is not credited):
  - mem_ready = (free >= 1).
  - alu_ready = mem_valid ? (free >= 2) : (free >= 1).
- Enqueue order when both transfer on the same edge: the mem entry is written first, then the ALU entry. The ALU value is therefore the final register value when both target the same index.
- Range check:
  - A transferred request with addr >= 16 is consumed but not enqueued.
  - drop_err pulses high for the following cycle; a pulse for both sources on one edge is a single pulse.
  - Index 0 is an ordinary writable register.
- Drain, every edge:
  - If count > 0: pop the head; wb_wr<=1, wb_controle<=head addr, wb_entrada<=head data.
  - Otherwise wb_wr<=0; wb_controle and wb_entrada hold their last values.
  - Exactly one pop per cycle. No combinational path from mem_*/alu_* to wb_*.
- Latency: a request accepted on edge N into an empty FIFO drives wb_wr=1 during cycle N+1..N+2. The register file captures it on edge N+2.
- Count: count_next = count + enqueued(0..2) - popped(0..1). Never exceeds DEPTH. Pointers wrap modulo DEPTH.
- Pending (combinational):
  - rs_pending = 1 if any valid FIFO entry has addr==rs, or (wb_wr & wb_controle==rs).
  - rt_pending is identical for rt.
  - Requests in the same cycle that have not yet transferred do not count.
- Simultaneous enqueue and dequeue with the FIFO full: no enqueue (ready was 0); the pop proceeds; ready rises the next cycle.
- Ordering is strictly FIFO. There is no write coalescing.

Test Plan:
- Reset release, idle: reset 0->1 with no valids -> wb_wr=0, count=0, mem_ready=1, alu_ready=1, both pending outputs 0.
- Single ALU write: alu_addr=9, alu_data=0xDEADBEEF accepted on edge N -> wb_wr=1, wb_controle=9, wb_entrada=0xDEADBEEF in cycle N+1; rs=9 gives rs_pending=1 from N+1 through N+2, 0 after.
- Dual same-index: mem (3, 0x11) and alu (3, 0x22) on one edge -> wb writes 0x11 then 0x22 to index 3 on consecutive cycles; count goes 2,1,0.
- Backpressure: both sources valid every cycle with distinct indices for 8 cycles, DEPTH=4 -> count never exceeds 4; alu_ready drops while free<2; every accepted write appears exactly once, in order.
- Out-of-range: alu_addr=20 accepted -> no wb_wr, drop_err=1 for one cycle, count unchanged.
- Async reset mid-drain: 3 entries queued, reset=0 mid-cycle -> wb_wr=0 immediately; after release count=0 and no further writes.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// Writeback queue: merges ALU and load-path writebacks into an in-order FIFO
// that feeds the 16-entry register file write port, one entry per cycle.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_addr,
    input  logic [DATA_W-1:0]      alu_data,
    output logic [ADDR_W-1:0]      wb_controle,
    output logic [DATA_W-1:0]      wb_entrada,
    output logic                   wb_wr,
    input  logic [ADDR_W-1:0]      rs,
    input  logic [ADDR_W-1:0]      rt,
    output logic                   rs_pending,
    output logic                   rt_pending,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, alu_slot;
    logic [CNT_W-1:0]  count_q, count_d, free_w;
    logic              wb_wr_q, wb_wr_d, drop_err_q, drop_err_d;
    logic [ADDR_W-1:0] wb_controle_q, wb_controle_d;
    logic [DATA_W-1:0] wb_entrada_q, wb_entrada_d;
    logic              mem_xfer, alu_xfer, mem_ok, alu_ok, pop;
    logic              rs_hit, rt_hit;
    logic [PTR_W-1:0]  idx;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> 4) == '0;
    endfunction

    // Handshake: a source transfers on a rising edge when valid && ready; ready is
    // computed from start-of-cycle occupancy only and never from that source's valid.
    assign free_w    = CNT_W'(DEPTH) - count_q;
    assign mem_ready = reset && (free_w >= CNT_W'(1));
    assign alu_ready = reset && (mem_valid ? (free_w >= CNT_W'(2)) : (free_w >= CNT_W'(1)));

    assign mem_xfer = mem_valid && mem_ready;
    assign alu_xfer = alu_valid && alu_ready;
    assign mem_ok   = mem_xfer && in_range(mem_addr);
    assign alu_ok   = alu_xfer && in_range(alu_addr);
    assign pop      = (count_q != '0);
    // The mem entry lands first so the ALU value wins on a same-index collision.
    assign alu_slot = wr_ptr_q + PTR_W'(mem_ok);

    always_comb begin
        wr_ptr_d      = wr_ptr_q + PTR_W'(mem_ok) + PTR_W'(alu_ok);
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
        count_d       = count_q + CNT_W'(mem_ok) + CNT_W'(alu_ok) - CNT_W'(pop);
        drop_err_d    = (mem_xfer && !mem_ok) || (alu_xfer && !alu_ok);
        wb_wr_d       = pop;
        wb_controle_d = wb_controle_q;
        wb_entrada_d  = wb_entrada_q;
        if (pop) begin
            wb_controle_d = addr_mem_q[rd_ptr_q];
            wb_entrada_d  = data_mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clock) begin
        if (mem_ok) begin
            addr_mem_q[wr_ptr_q] <= mem_addr;
            data_mem_q[wr_ptr_q] <= mem_data;
        end
        if (alu_ok) begin
            addr_mem_q[alu_slot] <= alu_addr;
            data_mem_q[alu_slot] <= alu_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wb_wr_q       <= 1'b0;
            wb_controle_q <= '0;
            wb_entrada_q  <= '0;
            drop_err_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wb_wr_q       <= wb_wr_d;
            wb_controle_q <= wb_controle_d;
            wb_entrada_q  <= wb_entrada_d;
            drop_err_q    <= drop_err_d;
        end
    end

    // An entry is live while its offset from the head is below the occupancy.
    always_comb begin
        rs_hit = wb_wr_q && (wb_controle_q == rs);
        rt_hit = wb_wr_q && (wb_controle_q == rt);
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (addr_mem_q[idx] == rs) rs_hit = 1'b1;
                if (addr_mem_q[idx] == rt) rt_hit = 1'b1;
            end
        end
    end

    assign rs_pending  = rs_hit;
    assign rt_pending  = rt_hit;
    assign wb_wr       = wb_wr_q;
    assign wb_controle = wb_controle_q;
    assign wb_entrada  = wb_entrada_q;
    assign count       = count_q;
    assign drop_err    = drop_err_q;
endmodule
